// File: rtl/dds_spi_mc.sv
// Multi-chip DDS serial loader: a PicoBlaze-style port window feeds a command FIFO
// whose entries are shifted out MSB first on a shared SCLK/SDATA pair with one FSYNC per chip.
module dds_spi_mc #(
    parameter int         NUM_CH     = 2,
    parameter int         WORD_W     = 16,
    parameter int         CLK_DIV    = 2,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] PORT_BASE  = 8'h10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        port_id,
    input  logic [7:0]        out_port,
    input  logic              write_strobe,
    output logic [NUM_CH-1:0] FSYNC,
    output logic              SCLK,
    output logic              SDATA,
    output logic [7:0]        status
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FW   = $clog2(WORD_W + 1);
    localparam int EW   = CH_W + WORD_W;

    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, GAP} state_t;

    // ---------------- register window decode ----------------
    logic [7:0] offs;
    logic       hit, wr_stage, wr_push, wr_flush, wr_clear, ch_ok;

    assign offs     = port_id - PORT_BASE;
    assign hit      = write_strobe && (offs[7:2] == 6'd0);
    assign wr_stage = hit && (offs[1:0] == 2'd0);
    assign wr_push  = hit && (offs[1:0] == 2'd1);
    assign wr_flush = hit && (offs[1:0] == 2'd2);
    assign wr_clear = hit && (offs[1:0] == 2'd3);
    assign ch_ok    = out_port < 8'(NUM_CH);

    // ---------------- staging register ----------------
    logic [WORD_W-1:0] staging, stage_shift;

    generate
        if (WORD_W > 8) begin : g_wide
            assign stage_shift = {staging[WORD_W-9:0], out_port};
        end else begin : g_narrow
            assign stage_shift = out_port;
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        staging <= '0;
        else if (wr_stage) staging <= stage_shift;
    end

    // ---------------- command FIFO ----------------
    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              full, empty, push_ok, pop;
    logic              overflow, bad_ch;
    logic [EW-1:0]     head;
    logic [CH_W-1:0]   head_ch;
    logic [WORD_W-1:0] head_word;
    state_t            state, state_n;

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign push_ok   = wr_push && ch_ok && !full;
    assign pop       = (state == IDLE) && !empty;
    assign head      = mem[rd_ptr];
    assign head_ch   = head[EW-1:WORD_W];
    assign head_word = head[WORD_W-1:0];

    // NOTE: the storage array has no reset; validity is carried entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {out_port[CH_W-1:0], staging};
    end

    // A flush only drops queued entries; a word already popped keeps shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (wr_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            bad_ch   <= 1'b0;
        end else if (wr_clear) begin
            overflow <= 1'b0;
            bad_ch   <= 1'b0;
        end else begin
            if (wr_push && full)   overflow <= 1'b1;
            if (wr_push && !ch_ok) bad_ch   <= 1'b1;
        end
    end

    // ---------------- serializer ----------------
    logic [CW-1:0]     cnt, cnt_n;
    logic [FW-1:0]     fall_cnt, fall_n;
    logic [WORD_W-1:0] shreg, shreg_n;
    logic              sclk_n, cnt_end;
    logic [NUM_CH-1:0] fsync_n;

    assign cnt_end = (cnt == CW'(CLK_DIV - 1));

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt_end ? '0 : cnt + 1'b1;
        fall_n  = fall_cnt;
        shreg_n = shreg;
        sclk_n  = SCLK;
        fsync_n = FSYNC;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!empty) begin
                    shreg_n = head_word;
                    fsync_n = ~(NUM_CH'(1) << head_ch);
                    sclk_n  = 1'b1;
                    fall_n  = '0;
                    state_n = SETUP;
                end
            end
            SETUP: if (cnt_end) begin
                sclk_n  = 1'b0;
                fall_n  = FW'(1);
                state_n = LOW;
            end
            LOW: if (cnt_end) begin
                sclk_n  = 1'b1;
                state_n = HIGH;
                if (fall_cnt != FW'(WORD_W)) shreg_n = shreg << 1;
            end
            // After the last rising edge FSYNC is held one more half-period before release.
            HIGH: if (cnt_end) begin
                if (fall_cnt == FW'(WORD_W)) begin
                    fsync_n = '1;
                    state_n = GAP;
                end else begin
                    sclk_n  = 1'b0;
                    fall_n  = fall_cnt + 1'b1;
                    state_n = LOW;
                end
            end
            GAP: if (cnt_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            fall_cnt <= '0;
            shreg    <= '0;
            SCLK     <= 1'b1;
            FSYNC    <= '1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            fall_cnt <= fall_n;
            shreg    <= shreg_n;
            SCLK     <= sclk_n;
            FSYNC    <= fsync_n;
        end
    end

    assign SDATA = shreg[WORD_W-1];

    // ---------------- status ----------------
    logic [31:0] count_ext;
    logic [2:0]  level;

    assign count_ext = 32'(count);
    assign level     = (count_ext > 32'd7) ? 3'd7 : count_ext[2:0];
    assign status    = {state != IDLE, full, empty, overflow, bad_ch, level};

endmodule

// File: tb/tb_dds_spi_mc.sv
// Self-checking bench for dds_spi_mc: directed scenarios plus randomized bursts,
// with frames decoded from the pins and compared against a command-level model.
module tb_dds_spi_mc;

    localparam int NUM_CH     = 2;
    localparam int WORD_W     = 16;
    localparam int CLK_DIV    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME_LOW  = (2 * WORD_W + 1) * CLK_DIV;
    localparam int MIN_GAP    = CLK_DIV + 1;
    // From idle the first accepted word is popped at once, so one burst holds DEPTH+1 words.
    localparam int BURST_CAP  = FIFO_DEPTH + 1;

    logic              clk, rst_n, write_strobe;
    logic [7:0]        port_id, out_port, status;
    logic [NUM_CH-1:0] FSYNC;
    logic              SCLK, SDATA;

    dds_spi_mc #(
        .NUM_CH(NUM_CH), .WORD_W(WORD_W), .CLK_DIV(CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH), .PORT_BASE(8'h10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .FSYNC(FSYNC), .SCLK(SCLK), .SDATA(SDATA),
        .status(status)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- pin-level frame monitor ----------------
    typedef struct {
        int          ch;
        logic [31:0] word;
        int          nbits;
        int          low_cyc;
        int          gap;
    } frame_t;

    frame_t obs[$];
    frame_t cur;
    bit     active    = 0;
    logic   prev_sclk = 1'b1;
    int     hi_cnt    = 1000;
    int     stray     = 0;
    int     multi_low = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            active = 0;
            hi_cnt = 1000;
        end else begin
            if (active) begin
                if (FSYNC == '1) begin
                    obs.push_back(cur);
                    active = 0;
                    hi_cnt = 1;
                end else begin
                    cur.low_cyc++;
                    if (prev_sclk && !SCLK) begin
                        cur.word = {cur.word[30:0], SDATA};
                        cur.nbits++;
                    end
                end
            end else if (FSYNC != '1) begin
                active      = 1;
                cur.ch      = -1;
                for (int i = NUM_CH - 1; i >= 0; i--) if (!FSYNC[i]) cur.ch = i;
                cur.word    = '0;
                cur.nbits   = 0;
                cur.low_cyc = 1;
                cur.gap     = hi_cnt;
            end else begin
                hi_cnt++;
                if (prev_sclk && !SCLK) stray++;
            end
            if ($countones(~FSYNC) > 1) multi_low++;
        end
        prev_sclk = SCLK;
    end

    // ---------------- command-level reference model ----------------
    typedef struct {
        int          ch;
        logic [15:0] word;
    } cmd_t;

    cmd_t        expq[$];
    logic [15:0] m_stage = '0;
    int          m_acc   = 0;
    logic        m_ovf   = 0;
    logic        m_bad   = 0;

    function automatic logic [15:0] stage_in(input logic [15:0] s, input logic [7:0] b);
        int v;
        v = (int'(s) * 256 + int'(b)) % 65536;
        return 16'(v);
    endfunction

    task automatic bus(input logic [7:0] p, input logic [7:0] d, input logic stb);
        port_id      = p;
        out_port     = d;
        write_strobe = stb;
        @(negedge clk);
        write_strobe = 1'b0;
    endtask

    task automatic stage_wr(input logic [7:0] b);
        bus(8'h10, b, 1'b1);
        m_stage = stage_in(m_stage, b);
    endtask

    task automatic push(input logic [7:0] ch);
        bus(8'h11, ch, 1'b1);
        if (int'(ch) >= NUM_CH) m_bad = 1'b1;
        if (m_acc >= BURST_CAP) m_ovf = 1'b1;
        if (int'(ch) < NUM_CH && m_acc < BURST_CAP) begin
            m_acc++;
            expq.push_back('{int'(ch), m_stage});
        end
    endtask

    task automatic noise();
        case ($urandom_range(0, 3))
            0: bus(8'h11, 8'($urandom_range(0, 255)), 1'b0);
            1: bus(8'h10, 8'($urandom_range(0, 255)), 1'b0);
            2: bus(8'h14, 8'($urandom_range(0, 255)), 1'b1);
            default: bus(8'h0F, 8'($urandom_range(0, 255)), 1'b1);
        endcase
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (!(status[7] == 1'b0 && status[5] == 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_timeout"}, 32'(n < budget), 32'd1);
    endtask

    task automatic compare_frames(input string tag);
        int n;
        check({tag, "_nframes"}, 32'(obs.size()), 32'(expq.size()));
        n = (obs.size() < expq.size()) ? obs.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_f%0d_ch", tag, i), 32'(obs[i].ch), 32'(expq[i].ch));
            check($sformatf("%s_f%0d_word", tag, i), obs[i].word, 32'(expq[i].word));
            check($sformatf("%s_f%0d_bits", tag, i), 32'(obs[i].nbits), 32'(WORD_W));
            check($sformatf("%s_f%0d_low", tag, i), 32'(obs[i].low_cyc), 32'(FRAME_LOW));
            if (i > 0)
                check($sformatf("%s_f%0d_gap", tag, i), 32'(obs[i].gap >= MIN_GAP), 32'd1);
        end
        obs.delete();
        expq.delete();
        m_acc = 0;
    endtask

    // ---------------- directed and random sequence ----------------
    int   falls, stray0, nb;
    logic prev;
    logic [7:0] ch;

    initial begin
        rst_n        = 1'b0;
        port_id      = 8'h00;
        out_port     = 8'h00;
        write_strobe = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_fsync", 32'(FSYNC), 32'h3);
        check("rst_sclk", 32'(SCLK), 32'd1);
        check("rst_sdata", 32'(SDATA), 32'd0);
        check("rst_status", 32'(status), 32'h20);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single frame to channel 1, staging rewritten mid-frame
        stage_wr(8'h21);
        stage_wr(8'h00);
        push(8'h01);
        repeat (3) @(negedge clk);
        check("single_fsync", 32'(FSYNC), 32'h1);
        check("single_busy", 32'(status[7]), 32'd1);
        stage_wr(8'hAA);
        wait_idle("single", 200);
        check("single_word_const", obs.size() > 0 ? obs[0].word : 32'hDEAD, 32'h2100);
        compare_frames("single");

        // overflow: six pushes to channel 0 inside one frame time
        for (int i = 0; i < 6; i++) begin
            stage_wr(8'(8'h30 + i));
            push(8'h00);
        end
        check("ovf_status", 32'(status), 32'hD4);
        wait_idle("ovf", 600);
        check("ovf_nframes_const", 32'(obs.size()), 32'd5);
        check("ovf_multi_low", 32'(multi_low), 32'd0);
        compare_frames("ovf");
        check("ovf_sticky", 32'(status[4]), 32'd1);
        bus(8'h13, 8'h00, 1'b1);
        m_ovf = 0;
        check("ovf_clear", 32'(status), 32'h20);

        // bad channel
        push(8'h05);
        check("badch_status", 32'(status), 32'h28);
        repeat (100) @(negedge clk);
        check("badch_noframe", 32'(obs.size()), 32'd0);
        expq.delete();
        bus(8'h13, 8'h00, 1'b1);
        m_bad = 0;
        check("badch_clear", 32'(status), 32'h20);

        // flush while the first frame is shifting
        stage_wr(8'h5C);
        push(8'h01);
        push(8'h00);
        push(8'h01);
        bus(8'h12, 8'h00, 1'b1);
        while (expq.size() > 1) void'(expq.pop_back());
        check("flush_status", 32'(status), 32'hA0);
        wait_idle("flush", 300);
        compare_frames("flush");

        // writes that must have no effect
        bus(8'h14, 8'h55, 1'b1);
        bus(8'h0F, 8'h66, 1'b1);
        bus(8'h10, 8'h77, 1'b0);
        bus(8'h11, 8'h00, 1'b0);
        bus(8'h12, 8'h00, 1'b0);
        check("noeffect_status", 32'(status), 32'h20);
        repeat (50) @(negedge clk);
        check("noeffect_noframe", 32'(obs.size()), 32'd0);
        push(8'h00);
        wait_idle("noeffect", 200);
        compare_frames("noeffect");

        // reset at the 7th falling SCLK edge with more words queued
        stage_wr(8'hA5);
        stage_wr(8'h5A);
        push(8'h00);
        push(8'h01);
        push(8'h00);
        falls = 0;
        prev  = SCLK;
        for (int i = 0; i < 300 && falls < 7; i++) begin
            @(negedge clk);
            if (prev && !SCLK) falls++;
            prev = SCLK;
        end
        check("rstmid_reach7", 32'(falls), 32'd7);
        rst_n = 1'b0;
        #1;
        check("rstmid_fsync", 32'(FSYNC), 32'h3);
        check("rstmid_sclk", 32'(SCLK), 32'd1);
        check("rstmid_status", 32'(status), 32'h20);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        m_stage = '0;
        m_acc   = 0;
        expq.delete();
        obs.delete();
        stray0  = stray;
        repeat (150) @(negedge clk);
        check("rstmid_noframe", 32'(obs.size()), 32'd0);
        check("rstmid_noedge", 32'(stray - stray0), 32'd0);
        check("rstmid_empty", 32'(status), 32'h20);
        stage_wr(8'h3C);
        push(8'h01);
        wait_idle("rstmid_new", 200);
        compare_frames("rstmid_new");

        // randomized bursts, each started from idle and shorter than one frame
        for (int b = 0; b < 6; b++) begin
            m_acc = 0;
            nb    = $urandom_range(1, 7);
            for (int k = 0; k < nb; k++) begin
                repeat ($urandom_range(1, 2)) stage_wr(8'($urandom_range(0, 255)));
                if ($urandom_range(0, 3) == 0) noise();
                case ($urandom_range(0, 7))
                    0, 2, 4: ch = 8'h00;
                    1, 3, 5: ch = 8'h01;
                    6:       ch = 8'h02;
                    default: ch = 8'hC3;
                endcase
                push(ch);
            end
            wait_idle($sformatf("rnd%0d", b), 700);
            compare_frames($sformatf("rnd%0d", b));
            check($sformatf("rnd%0d_ovf", b), 32'(status[4]), 32'(m_ovf));
            check($sformatf("rnd%0d_bad", b), 32'(status[3]), 32'(m_bad));
            bus(8'h13, 8'h00, 1'b1);
            m_ovf = 0;
            m_bad = 0;
            check($sformatf("rnd%0d_clear", b), 32'(status), 32'h20);
        end

        check("final_multi_low", 32'(multi_low), 32'd0);
        check("final_stray", 32'(stray), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
